// File: rtl/router_packet_tx_if.sv
// Local-source write port and router-side valid/ready port of router_packet_tx.
// master = source/router side, slave = the transmitter.
interface router_packet_tx_if #(
    parameter int unsigned DEPTH = 4
);
    logic                    wr_en;
    logic [2:0]              wr_addr;
    logic [4:0]              wr_spare;
    logic                    wr_full;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [7:0]              drop_cnt;
    logic [15:0]             data_out;
    logic                    valid_out;
    logic                    ready_in;

    modport master (
        output wr_en, wr_addr, wr_spare, ready_in,
        input  wr_full, fifo_count, drop_cnt, data_out, valid_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_spare, ready_in,
        output wr_full, fifo_count, drop_cnt, data_out, valid_out
    );
endinterface

// File: rtl/router_packet_tx.sv
// Buffers local writes in a small FIFO and sends each entry as a 16-bit even-parity router
// word {addr, seq, parity, spare} over valid/ready, with a programmable idle gap per transfer.
module router_packet_tx #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter logic [6:0]  SEQ_INIT   = 7'd0
) (
    input  logic               clk,
    input  logic               reset,
    router_packet_tx_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [3:0]    GapLoad   = 4'(GAP_CYCLES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    drop_q, drop_d;
    logic [6:0]    seq_q, seq_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    gap_q, gap_d;
    logic          full, empty, push, pop;
    logic [2:0]    head_addr;
    logic [4:0]    head_spare;

    always_comb begin
        full       = (count_q == FullCount);
        empty      = (count_q == '0);
        push       = bus.wr_en && !full;
        head_addr  = mem_q[rptr_q][7:5];
        head_spare = mem_q[rptr_q][4:0];
        pop        = 1'b0;
        state_d    = state_q;
        valid_d    = valid_q;
        gap_d      = gap_q;
        data_d     = data_q;
        seq_d      = seq_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        drop_d     = drop_q;

        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (bus.ready_in) begin
                    if (GAP_CYCLES != 0) begin
                        valid_d = 1'b0;
                        gap_d   = GapLoad;
                        state_d = StGap;
                    end else if (!empty) begin
                        pop = 1'b1;  // back-to-back: valid_out stays high
                    end else begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_q <= 4'd1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase

        // Sequence number is stamped at pop time, so dropped writes never consume one.
        if (pop) begin
            data_d = {head_addr, seq_q, ^{head_addr, seq_q, head_spare}, head_spare};
            seq_d  = seq_q + 7'd1;
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        // Fullness comes from the registered count; a same-cycle pop never rescues a write.
        if (bus.wr_en && full && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            gap_q   <= '0;
            data_q  <= '0;
            seq_q   <= SEQ_INIT;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            seq_q   <= seq_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {bus.wr_addr, bus.wr_spare};
        end
    end

    assign bus.wr_full    = full;
    assign bus.fifo_count = count_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
endmodule
